bnn_param_loader: RTL and testbench
===================================

// Module: bnn_param_loader
// PURPOSE
//  Upstream stage of the tiny BNN core: streams host bytes bit-serially into the neuron parameter chain.
//  Drives the core's setup/param_in pins and collects the chain tail (param_out) as readback bytes.
//  One load = exactly CHAIN_BITS shift edges, so a host can replace and read back the full weight/bias image.
// PARAMETERS
//  CHAIN_BITS  216  total bits in the parameter chain (all layers, head to tail)
//  BYTE_W      8    width of host byte interface
// PORTS
//  clk         in   1       core clock; all chain shifts occur on posedge
//  rst_n       in   1       asynchronous, active-low reset
//  start       in   1       1-cycle pulse: begin a load; ignored while busy
//  byte_in     in   BYTE_W  next parameter byte, MSB shifted first
//  byte_valid  in   1       byte_in valid
//  byte_ready  out  1       loader can accept byte_in this cycle
//  setup       out  1       to core setup; high = chain shifts one bit this edge
//  param_in    out  1       to core param_in (chain head)
//  param_out   in   1       from core chain tail (io_out[7] while setup=1)
//  rb_byte     out  BYTE_W  readback byte of displaced old chain contents
//  rb_valid    out  1       1-cycle pulse, rb_byte valid; no backpressure
//  busy        out  1       load in progress
//  done        out  1       1-cycle pulse after final shift edge
// BEHAVIOUR
//  Reset (async, rst_n=0): setup=0, param_in=0, byte_ready=0, busy=0, done=0, rb_valid=0, rb_byte=0;
//   bit counter, holding buffer, shift reg cleared; state=IDLE. Reset mid-load leaves chain partially
//   loaded; setup falls immediately (async), so no further chain edges occur.
//  FSM: IDLE -start-> FETCH; FETCH -byte accepted-> SHIFT; SHIFT -8 bits done, buffer full-> SHIFT;
//   SHIFT -8 bits done, buffer empty, bits remain-> FETCH; SHIFT -last bit-> DONE; DONE -> IDLE (1 cycle).
//  Handshake: transfer when byte_valid && byte_ready. byte_ready=1 in FETCH, and in SHIFT while the
//   one-entry holding buffer is empty and further bytes are still owed. Never high in IDLE/DONE.
//  Throughput: with holding buffer refilled in time, setup stays high continuously, 1 bit/clk.
//  Stall: buffer empty at byte boundary -> setup=0 (chain frozen) until next byte accepted; no bit lost.
//  setup=1 only in cycles where param_in carries a valid bit; count of setup-high edges per load
//   equals CHAIN_BITS exactly.
//  Bit order: byte MSB first; first byte lands deepest (output layer tail) after full load.
//  Partial final byte: if CHAIN_BITS%BYTE_W != 0, only the top CHAIN_BITS%BYTE_W bits of last byte
//   shift; low bits discarded. Bytes owed = ceil(CHAIN_BITS/BYTE_W).
//  Readback: param_out sampled on each setup-high edge, packed MSB first; rb_valid pulses the cycle
//   after the 8th sample of each byte; final partial byte left-aligned, zero-padded, pulsed at DONE.
//  done pulses in DONE; busy=1 from cycle after start through DONE inclusive; busy=0 in IDLE.
//  start during busy: ignored. start and reset coincident: reset wins.
//  Bit counter width $clog2(CHAIN_BITS+1); saturates at CHAIN_BITS, never wraps.
// STRUCTURE
//  bnn_pkg: loader state enum (IDLE/FETCH/SHIFT/DONE), CHAIN_BITS default, BYTE_W, bytes-owed function.
//  Sub-module bnn_byte_serializer: holding buffer + 8-bit shift reg + bit index, emits bit/valid;
//   top holds FSM, global bit counter, readback packer.
// TESTING
//  Reset, start, feed 27 bytes back-to-back (valid always 1) -> setup high 216 consecutive cycles,
//   done pulse 1 cycle after last edge, 27 byte handshakes.
//  Load image A then image B -> 27 rb_valid pulses during B reproduce A byte-for-byte.
//  Insert 5-cycle gap in byte_valid after byte 3 -> setup low exactly during starvation, total setup
//   edges still 216, chain content = fed image.
//  CHAIN_BITS=20: feed 0xA5,0x3C,0xFF -> 20 edges, param_in seq 1010_0101_0011_1100_1111, last rb byte padded.
//  Assert rst_n low at bit 100 -> setup drops same cycle, busy=0; new start then full load succeeds.
//  start pulses while busy and byte_valid in IDLE -> no effect, byte_ready stays 0 in IDLE.

Source files
------------

// File: rtl/bnn_pkg.sv
// rtl/bnn_pkg.sv - shared types and sizing helpers for the BNN parameter loader
package bnn_pkg;

    localparam int CHAIN_BITS_DEF = 216;
    localparam int BYTE_W_DEF     = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } load_state_e;

    function automatic int bytes_owed(input int bits, input int w);
        return (bits + w - 1) / w;
    endfunction

endpackage

// File: rtl/bnn_byte_serializer.sv
// rtl/bnn_byte_serializer.sv - one-entry holding buffer feeding an MSB-first bit shifter
module bnn_byte_serializer
    import bnn_pkg::*;
#(
    parameter int BYTE_W = BYTE_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              load,
    input  logic [BYTE_W-1:0] byte_in,
    input  logic              shift,
    output logic              bit_out,
    output logic              bit_valid,
    output logic              last_bit,
    output logic              buf_full
);

    localparam int IDX_W = $clog2(BYTE_W + 1);

    logic [BYTE_W-1:0] sr_q, sr_d;
    logic [BYTE_W-1:0] buf_q, buf_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              buf_full_q, buf_full_d;
    logic              sr_empties;

    always_comb begin
        sr_d       = sr_q;
        idx_d      = idx_q;
        buf_d      = buf_q;
        buf_full_d = buf_full_q;
        sr_empties = (idx_q == '0) || ((idx_q == IDX_W'(1)) && shift);
        if (clr) begin
            sr_d       = '0;
            idx_d      = '0;
            buf_d      = '0;
            buf_full_d = 1'b0;
        end else begin
            if (shift && (idx_q != '0)) begin
                sr_d  = {sr_q[BYTE_W-2:0], 1'b0};
                idx_d = idx_q - IDX_W'(1);
            end
            // A byte arriving as the shifter drains goes straight in, keeping setup continuous.
            if (sr_empties && buf_full_q) begin
                sr_d       = buf_q;
                idx_d      = IDX_W'(BYTE_W);
                buf_full_d = 1'b0;
            end else if (sr_empties && load) begin
                sr_d  = byte_in;
                idx_d = IDX_W'(BYTE_W);
            end else if (load) begin
                buf_d      = byte_in;
                buf_full_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_q       <= '0;
            idx_q      <= '0;
            buf_q      <= '0;
            buf_full_q <= 1'b0;
        end else begin
            sr_q       <= sr_d;
            idx_q      <= idx_d;
            buf_q      <= buf_d;
            buf_full_q <= buf_full_d;
        end
    end

    assign bit_out   = sr_q[BYTE_W-1];
    assign bit_valid = (idx_q != '0);
    assign last_bit  = (idx_q == IDX_W'(1));
    assign buf_full  = buf_full_q;

endmodule

// File: rtl/bnn_param_loader.sv
// rtl/bnn_param_loader.sv - streams host bytes into the BNN parameter chain and packs displaced bits for readback
module bnn_param_loader
    import bnn_pkg::*;
#(
    parameter int CHAIN_BITS = CHAIN_BITS_DEF,
    parameter int BYTE_W     = BYTE_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [BYTE_W-1:0] byte_in,
    input  logic              byte_valid,
    output logic              byte_ready,
    output logic              setup,
    output logic              param_in,
    input  logic              param_out,
    output logic [BYTE_W-1:0] rb_byte,
    output logic              rb_valid,
    output logic              busy,
    output logic              done
);

    localparam int CNT_W  = $clog2(CHAIN_BITS + 1);
    localparam int BYTES  = bytes_owed(CHAIN_BITS, BYTE_W);
    localparam int BCNT_W = $clog2(BYTES + 1);
    localparam int RB_W   = $clog2(BYTE_W);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(CHAIN_BITS - 1);

    load_state_e       state_q, state_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [BCNT_W-1:0] byte_cnt_q, byte_cnt_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [BYTE_W-1:0] rb_sr_q, rb_sr_d;
    logic [RB_W-1:0]   rb_cnt_q, rb_cnt_d;
    logic [BYTE_W-1:0] rb_byte_q, rb_byte_d;
    logic              rb_valid_q, rb_valid_d;

    logic              ser_bit, ser_valid, ser_last, ser_buf_full;
    logic              ser_shift, ser_clr, accept, last_edge;
    logic [BYTE_W-1:0] rb_word;

    assign ser_shift  = (state_q == ST_SHIFT) && ser_valid;
    assign ser_clr    = (state_q == ST_IDLE) || (state_q == ST_DONE);
    assign byte_ready = (state_q == ST_FETCH) ||
                        ((state_q == ST_SHIFT) && !ser_buf_full && (byte_cnt_q < BCNT_W'(BYTES)));
    assign accept     = byte_valid && byte_ready;
    assign last_edge  = ser_shift && (bit_cnt_q == LAST_IDX);
    assign rb_word    = {rb_sr_q[BYTE_W-2:0], param_out};

    bnn_byte_serializer #(
        .BYTE_W(BYTE_W)
    ) u_ser (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (ser_clr),
        .load     (accept),
        .byte_in  (byte_in),
        .shift    (ser_shift),
        .bit_out  (ser_bit),
        .bit_valid(ser_valid),
        .last_bit (ser_last),
        .buf_full (ser_buf_full)
    );

    always_comb begin
        state_d    = state_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        rb_valid_d = 1'b0;
        rb_byte_d  = rb_byte_q;
        bit_cnt_d  = bit_cnt_q;
        byte_cnt_d = byte_cnt_q;
        rb_sr_d    = rb_sr_q;
        rb_cnt_d   = rb_cnt_q;

        if (accept) begin
            byte_cnt_d = byte_cnt_q + BCNT_W'(1);
        end

        if (ser_shift) begin
            if (bit_cnt_q != CNT_W'(CHAIN_BITS)) begin
                bit_cnt_d = bit_cnt_q + CNT_W'(1);
            end
            rb_sr_d  = rb_word;
            rb_cnt_d = rb_cnt_q + RB_W'(1);
            if (rb_cnt_q == RB_W'(BYTE_W - 1)) begin
                rb_byte_d  = rb_word;
                rb_valid_d = 1'b1;
            end else if (last_edge) begin
                // Short tail byte: left-align the collected bits, zeros below.
                rb_byte_d  = rb_word << (RB_W'(BYTE_W - 1) - rb_cnt_q);
                rb_valid_d = 1'b1;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d    = ST_FETCH;
                    busy_d     = 1'b1;
                    bit_cnt_d  = '0;
                    byte_cnt_d = '0;
                    rb_sr_d    = '0;
                    rb_cnt_d   = '0;
                end
            end
            ST_FETCH: begin
                if (accept) begin
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (last_edge) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end else if (ser_shift && ser_last && !ser_buf_full && !accept) begin
                    state_d = ST_FETCH;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            bit_cnt_q  <= '0;
            byte_cnt_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            rb_sr_q    <= '0;
            rb_cnt_q   <= '0;
            rb_byte_q  <= '0;
            rb_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            rb_sr_q    <= rb_sr_d;
            rb_cnt_q   <= rb_cnt_d;
            rb_byte_q  <= rb_byte_d;
            rb_valid_q <= rb_valid_d;
        end
    end

    assign setup    = ser_shift;
    assign param_in = ser_shift & ser_bit;
    assign rb_byte  = rb_byte_q;
    assign rb_valid = rb_valid_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_bnn_param_loader.sv
// tb/tb_bnn_param_loader.sv - self-checking bench for bnn_param_loader with behavioural chain models
module tb_bnn_param_loader;

    localparam int CB  = 216;
    localparam int NB  = 27;
    localparam int CB2 = 20;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, start, byte_valid, byte_ready, setup, param_in, param_out;
    logic       rb_valid, busy, done;
    logic [7:0] byte_in, rb_byte;
    logic       start2, byte_valid2, byte_ready2, setup2, param_in2, param_out2;
    logic       rb_valid2, busy2, done2;
    logic [7:0] byte_in2, rb_byte2;

    bnn_param_loader #(.CHAIN_BITS(CB), .BYTE_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .byte_in(byte_in), .byte_valid(byte_valid),
        .byte_ready(byte_ready), .setup(setup), .param_in(param_in), .param_out(param_out),
        .rb_byte(rb_byte), .rb_valid(rb_valid), .busy(busy), .done(done)
    );

    bnn_param_loader #(.CHAIN_BITS(CB2), .BYTE_W(8)) dut20 (
        .clk(clk), .rst_n(rst_n), .start(start2), .byte_in(byte_in2), .byte_valid(byte_valid2),
        .byte_ready(byte_ready2), .setup(setup2), .param_in(param_in2), .param_out(param_out2),
        .rb_byte(rb_byte2), .rb_valid(rb_valid2), .busy(busy2), .done(done2)
    );

    // Core parameter chains: head takes param_in, tail drives param_out.
    logic [CB-1:0]  chain_q  = '0;
    logic [CB2-1:0] chain2_q = '0;
    logic sh_en = 1'b0, sh_bit = 1'b0, sh2_en = 1'b0, sh2_bit = 1'b0;
    assign param_out  = chain_q[CB-1];
    assign param_out2 = chain2_q[CB2-1];
    always @(posedge clk) begin
        if (sh_en)  chain_q  <= {chain_q[CB-2:0], sh_bit};
        if (sh2_en) chain2_q <= {chain2_q[CB2-2:0], sh2_bit};
    end

    int cyc = 0, edges = 0, hs = 0, dones = 0, last_edge_cyc = 0, done_gap = 0;
    int viol = 0, idle_viol = 0, run_cur = 0, run_max = 0, load_acc = 0, load_edges = 0;
    logic       pin_q[$];
    logic [7:0] rb_q[$];
    int edges2 = 0, hs2 = 0, dones2 = 0;
    logic [31:0] pins2 = '0;
    logic [7:0]  rb2_q[$];

    always @(negedge clk) begin
        cyc++;
        sh_en = setup;   sh_bit = param_in;
        sh2_en = setup2; sh2_bit = param_in2;
        if (!rst_n) begin
            load_acc = 0; load_edges = 0; run_cur = 0; run_max = 0;
        end else begin
            if (start && !busy) begin load_acc = 0; load_edges = 0; run_max = 0; end
            // A bit may shift exactly when accepted bits exceed bits already shifted.
            if (busy && (setup !== (((load_acc < CB) ? load_acc : CB) > load_edges))) viol++;
            if (!busy && (byte_ready || setup)) idle_viol++;
            if (byte_valid && byte_ready) begin hs++; load_acc += 8; end
            if (setup) begin
                edges++; load_edges++; pin_q.push_back(param_in); last_edge_cyc = cyc;
                run_cur++; if (run_cur > run_max) run_max = run_cur;
            end else begin
                run_cur = 0;
            end
            if (rb_valid) rb_q.push_back(rb_byte);
            if (done) begin dones++; done_gap = cyc - last_edge_cyc; end
            if (setup2) begin edges2++; pins2 = {pins2[30:0], param_in2}; end
            if (byte_valid2 && byte_ready2) hs2++;
            if (rb_valid2) rb2_q.push_back(rb_byte2);
            if (done2) dones2++;
        end
    end

    int n_pass = 0, n_total = 0;

    task automatic chk(input string name, input logic [255:0] got, input logic [255:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    task automatic load_main(input logic [7:0] img[NB], input int gap_at, input int gap_len,
                             input bit spam, input int abort_at, input string tag);
        logic [CB-1:0] old_img, exp_img;
        int e0, h0, d0, v0, iv0, r0, p0, waitc, mism;
        bit took;
        old_img = chain_q;
        e0 = edges; h0 = hs; d0 = dones; v0 = viol; iv0 = idle_viol; r0 = rb_q.size(); p0 = pin_q.size();
        for (int i = 0; i < NB; i++) exp_img[CB-1-8*i -: 8] = img[i];
        start = 1'b1; @(posedge clk); #1; start = 1'b0;
        for (int i = 0; i < NB; i++) begin
            if (i == gap_at) begin
                repeat (gap_len) begin
                    byte_valid = 1'b0; start = spam && ($urandom_range(1) == 1);
                    @(posedge clk); #1;
                end
            end
            byte_valid = 1'b1; byte_in = img[i];
            took = 1'b0; waitc = 0;
            while (!took && waitc < 100) begin
                start = spam && ($urandom_range(1) == 1);
                @(negedge clk); took = byte_ready;
                @(posedge clk); #1; waitc++;
                if (abort_at > 0 && (edges - e0) >= abort_at) begin
                    rst_n = 1'b0; #1;
                    chk({tag, " abort setup"}, setup, 1'b0);
                    chk({tag, " abort busy"}, busy, 1'b0);
                    chk({tag, " abort ready"}, byte_ready, 1'b0);
                    byte_valid = 1'b0; start = 1'b0;
                    @(posedge clk); #1; rst_n = 1'b1;
                    @(posedge clk); #1;
                    return;
                end
            end
            if (!took) begin chk({tag, " byte accept"}, took, 1'b1); break; end
        end
        byte_valid = 1'b0; start = 1'b0;
        waitc = 0;
        while (dones == d0 && waitc < 600) begin @(posedge clk); #1; waitc++; end
        repeat (2) @(posedge clk); #1;
        chk({tag, " done count"}, dones - d0, 1);
        chk({tag, " done gap"}, done_gap, 1);
        chk({tag, " edges"}, edges - e0, CB);
        chk({tag, " handshakes"}, hs - h0, NB);
        chk({tag, " rb count"}, rb_q.size() - r0, NB);
        mism = 0;
        for (int k = 0; k < NB && (r0 + k) < rb_q.size(); k++)
            if (rb_q[r0+k] !== old_img[CB-1-8*k -: 8]) mism++;
        chk({tag, " rb mismatches"}, mism, 0);
        mism = 0;
        for (int k = 0; k < CB && (p0 + k) < pin_q.size(); k++)
            if (pin_q[p0+k] !== exp_img[CB-1-k]) mism++;
        chk({tag, " param_in mismatches"}, mism, 0);
        chk({tag, " chain"}, chain_q, exp_img);
        chk({tag, " setup rule"}, viol - v0, 0);
        chk({tag, " idle quiet"}, idle_viol - iv0, 0);
        chk({tag, " busy after"}, busy, 1'b0);
        if (gap_len == 0) chk({tag, " setup run"}, run_max, CB);
        if (gap_len >= 16) chk({tag, " stalled"}, run_max < CB, 1'b1);
    endtask

    task automatic load20(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2, input string tag);
        logic [23:0]    all;
        logic [CB2-1:0] old_img;
        logic [7:0]     exp_rb[3];
        int e0, h0, d0, r0, waitc;
        bit took;
        all = {b0, b1, b2};
        old_img = chain2_q;
        exp_rb[0] = old_img[19:12]; exp_rb[1] = old_img[11:4]; exp_rb[2] = {old_img[3:0], 4'h0};
        e0 = edges2; h0 = hs2; d0 = dones2; r0 = rb2_q.size();
        start2 = 1'b1; @(posedge clk); #1; start2 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            byte_valid2 = 1'b1; byte_in2 = all[23-8*i -: 8];
            took = 1'b0; waitc = 0;
            while (!took && waitc < 100) begin
                @(negedge clk); took = byte_ready2;
                @(posedge clk); #1; waitc++;
            end
            if (!took) begin chk({tag, " byte accept"}, took, 1'b1); break; end
        end
        byte_valid2 = 1'b0;
        waitc = 0;
        while (dones2 == d0 && waitc < 200) begin @(posedge clk); #1; waitc++; end
        repeat (2) @(posedge clk); #1;
        chk({tag, " done count"}, dones2 - d0, 1);
        chk({tag, " edges"}, edges2 - e0, CB2);
        chk({tag, " handshakes"}, hs2 - h0, 3);
        chk({tag, " param_in seq"}, pins2[CB2-1:0], all[23:4]);
        chk({tag, " chain"}, chain2_q, all[23:4]);
        chk({tag, " rb count"}, rb2_q.size() - r0, 3);
        for (int k = 0; k < 3 && (r0 + k) < rb2_q.size(); k++)
            chk({tag, " rb byte"}, rb2_q[r0+k], exp_rb[k]);
    endtask

    typedef struct {
        logic       st;
        logic       vld;
        logic [7:0] data;
        logic       e_busy, e_ready, e_setup, e_pin, e_done;
    } vec_t;

    vec_t       vecs[6];
    logic [7:0] img_a[NB], img_b[NB], img_c[NB], img_d[NB], img_e[NB], img_f[NB];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; start = 1'b1; byte_valid = 1'b0; byte_in = 8'h00;
        start2 = 1'b0; byte_valid2 = 1'b0; byte_in2 = 8'h00;
        repeat (3) @(posedge clk); #1;
        chk("reset setup", setup, 1'b0);
        chk("reset param_in", param_in, 1'b0);
        chk("reset ready", byte_ready, 1'b0);
        chk("reset busy with start", busy, 1'b0);
        chk("reset done", done, 1'b0);
        chk("reset rb_valid", rb_valid, 1'b0);
        chk("reset rb_byte", rb_byte, 8'h00);
        start = 1'b0; rst_n = 1'b1;
        @(posedge clk); #1;

        vecs[0] = '{1'b0, 1'b1, 8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{1'b0, 1'b1, 8'h80, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[5] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 6; i++) begin
            start = vecs[i].st; byte_valid = vecs[i].vld; byte_in = vecs[i].data;
            @(posedge clk); #1;
            chk($sformatf("vec%0d busy", i), busy, vecs[i].e_busy);
            chk($sformatf("vec%0d ready", i), byte_ready, vecs[i].e_ready);
            chk($sformatf("vec%0d setup", i), setup, vecs[i].e_setup);
            chk($sformatf("vec%0d param_in", i), param_in, vecs[i].e_pin);
            chk($sformatf("vec%0d done", i), done, vecs[i].e_done);
        end
        start = 1'b0; byte_valid = 1'b0;
        rst_n = 1'b0; @(posedge clk); #1; rst_n = 1'b1; @(posedge clk); #1;

        for (int i = 0; i < NB; i++) begin
            img_a[i] = 8'($urandom); img_b[i] = 8'($urandom); img_c[i] = 8'($urandom);
            img_d[i] = 8'($urandom); img_e[i] = 8'($urandom); img_f[i] = 8'($urandom);
        end

        load_main(img_a, -1, 0, 1'b0, 0, "A");
        load_main(img_b, -1, 0, 1'b0, 0, "B");
        load_main(img_c, 3, 5, 1'b1, 0, "C gap5");
        load_main(img_d, 10, 20, 1'b0, 0, "D gap20");
        load_main(img_e, -1, 0, 1'b0, 100, "E abort");
        load_main(img_f, -1, 0, 1'b0, 0, "F");

        load20(8'hA5, 8'h3C, 8'hFF, "W20 first");
        chk("W20 spec sequence", pins2[CB2-1:0], 20'b1010_0101_0011_1100_1111);
        load20(8'h12, 8'h34, 8'h56, "W20 second");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
